// File: rtl/prbs_bit_source_if.sv
// Control/data bundle for prbs_bit_source: seed/mode load, enable and the emitted
// bit stream with its counter and period strobe.
interface prbs_bit_source_if #(
    parameter int NB_SEED  = 15,
    parameter int NB_COUNT = 32
);
    logic                i_enable;
    logic                i_load;
    logic [NB_SEED-1:0]  i_seed;
    logic [1:0]          i_mode;
    logic                o_bit;
    logic                o_valid;
    logic [NB_COUNT-1:0] o_bit_count;
    logic                o_period_strobe;

    modport master (
        output i_enable, i_load, i_seed, i_mode,
        input  o_bit, o_valid, o_bit_count, o_period_strobe
    );

    modport slave (
        input  i_enable, i_load, i_seed, i_mode,
        output o_bit, o_valid, o_bit_count, o_period_strobe
    );
endinterface

// File: rtl/prbs_bit_source.sv
// PRBS7/9/15 Fibonacci bit source with seed load, emitted-bit counter and period strobe.
// Optional periodic bit inversion is built when PRBS_ERROR_INJECT_EN is defined.
module prbs_bit_source #(
    parameter int NB_SEED    = 15,
    parameter int NB_COUNT   = 32,
    parameter int ERR_PERIOD = 1000
) (
    input  logic             clock,
    input  logic             i_reset_n,
    prbs_bit_source_if.slave bus
);
    localparam int                  NB_PER     = 15;
    localparam logic [1:0]          MODE_PRBS7 = 2'b00;
    localparam logic [1:0]          MODE_PRBS9 = 2'b01;
    localparam logic [1:0]          MODE_PRBS15 = 2'b10;
    localparam logic [NB_SEED-1:0]  SEED_ZERO  = {NB_SEED{1'b0}};
    localparam logic [NB_SEED-1:0]  STATE_RST  = {{(NB_SEED-7){1'b0}}, 7'h7F};
    localparam logic [NB_COUNT-1:0] COUNT_ZERO = {NB_COUNT{1'b0}};
    localparam logic [NB_COUNT-1:0] COUNT_ONE  = {{(NB_COUNT-1){1'b0}}, 1'b1};

    // Low n bits set for the polynomial of the given mode; reserved code acts as PRBS7.
    function automatic logic [NB_SEED-1:0] order_mask(input logic [1:0] mode);
        logic [NB_SEED-1:0] m;
        m = SEED_ZERO;
        case (mode)
            MODE_PRBS9:  m[8:0]  = 9'h1FF;
            MODE_PRBS15: m[14:0] = 15'h7FFF;
            default:     m[6:0]  = 7'h7F;
        endcase
        return m;
    endfunction

    function automatic logic lfsr_feedback(input logic [NB_SEED-1:0] s, input logic [1:0] mode);
        logic fb;
        case (mode)
            MODE_PRBS9:  fb = s[8] ^ s[4];
            MODE_PRBS15: fb = s[14] ^ s[13];
            default:     fb = s[6] ^ s[5];
        endcase
        return fb;
    endfunction

    function automatic logic [NB_PER-1:0] period_last(input logic [1:0] mode);
        logic [NB_PER-1:0] p;
        case (mode)
            MODE_PRBS9:  p = 15'd511;
            MODE_PRBS15: p = 15'd32767;
            default:     p = 15'd127;
        endcase
        return p;
    endfunction

    logic [NB_SEED-1:0]  r_state;
    logic [1:0]          r_mode;
    logic                r_bit;
    logic                r_valid;
    logic [NB_COUNT-1:0] r_count;
    logic                r_strobe;
    logic [NB_PER-1:0]   r_period;

    logic                w_fb;
    logic                w_bit_out;
    logic [NB_SEED-1:0]  w_next_state;
    logic [NB_SEED-1:0]  w_load_mask;
    logic [NB_SEED-1:0]  w_seed_masked;
    logic [NB_SEED-1:0]  w_load_state;
    logic                w_period_wrap;

    // Next LFSR step, load value with lock-up protection, and period wrap detect.
    always_comb begin
        w_fb          = lfsr_feedback(r_state, r_mode);
        w_next_state  = {r_state[NB_SEED-2:0], w_fb} & order_mask(r_mode);
        w_load_mask   = order_mask(bus.i_mode);
        w_seed_masked = bus.i_seed & w_load_mask;
        if (w_seed_masked == SEED_ZERO) begin
            w_load_state = w_load_mask;
        end else begin
            w_load_state = w_seed_masked;
        end
        w_period_wrap = ((r_period + 15'd1) == period_last(r_mode));
    end

`ifdef PRBS_ERROR_INJECT_EN
    localparam int               NB_ERR   = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;
    localparam logic [NB_ERR-1:0] ERR_LAST = NB_ERR'(ERR_PERIOD - 1);
    localparam logic [NB_ERR-1:0] ERR_ZERO = {NB_ERR{1'b0}};
    localparam logic [NB_ERR-1:0] ERR_ONE  = NB_ERR'(1);

    logic [NB_ERR-1:0] r_err_cnt;
    logic              w_err_hit;

    // The ERR_PERIOD-th emitted bit since load/reset is the one to invert.
    always_comb begin
        w_err_hit = (r_err_cnt == ERR_LAST);
        w_bit_out = w_fb ^ w_err_hit;
    end

    // Emitted-bit counter modulo ERR_PERIOD; the LFSR itself is never disturbed.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_err_cnt <= ERR_ZERO;
        end else if (bus.i_load) begin
            r_err_cnt <= ERR_ZERO;
        end else if (bus.i_enable) begin
            r_err_cnt <= w_err_hit ? ERR_ZERO : (r_err_cnt + ERR_ONE);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end
`else
    // No injection: the emitted bit is the raw feedback.
    always_comb begin
        w_bit_out = w_fb;
    end
`endif

    // LFSR state, mode, emitted bit, counters and strobe; load overrides enable.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= STATE_RST;
            r_mode   <= MODE_PRBS7;
            r_bit    <= 1'b0;
            r_valid  <= 1'b0;
            r_count  <= COUNT_ZERO;
            r_strobe <= 1'b0;
            r_period <= 15'd0;
        end else if (bus.i_load) begin
            r_state  <= w_load_state;
            r_mode   <= bus.i_mode;
            r_valid  <= 1'b0;
            r_count  <= COUNT_ZERO;
            r_strobe <= 1'b0;
            r_period <= 15'd0;
        end else if (bus.i_enable) begin
            r_state  <= w_next_state;
            r_bit    <= w_bit_out;
            r_valid  <= 1'b1;
            r_count  <= r_count + COUNT_ONE;
            r_strobe <= w_period_wrap;
            r_period <= w_period_wrap ? 15'd0 : (r_period + 15'd1);
        end else begin
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
        end
    end

    assign bus.o_bit           = r_bit;
    assign bus.o_valid         = r_valid;
    assign bus.o_bit_count     = r_count;
    assign bus.o_period_strobe = r_strobe;
endmodule

// File: tb/tb_prbs_bit_source.sv
// Randomized bench for prbs_bit_source against a bit-stream recurrence model
// a[k] = a[k-n] ^ a[k-t], with the seed supplying the initial history.
`timescale 1ns/1ps
module tb_prbs_bit_source;
`ifdef PRBS_ERROR_INJECT_EN
    localparam int ERRP = 10;
    localparam bit INJ  = 1'b1;
`else
    localparam int ERRP = 1000;
    localparam bit INJ  = 1'b0;
`endif

    logic clock = 1'b0;
    logic i_reset_n;
    always #5 clock = ~clock;

    prbs_bit_source_if #(.NB_SEED(15), .NB_COUNT(32)) bus();

    prbs_bit_source #(.NB_SEED(15), .NB_COUNT(32), .ERR_PERIOD(ERRP)) dut (
        .clock     (clock),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit          hist[$];
    int          m_n;
    int          m_t;
    longint      since_load;
    bit          g_bit;
    logic        exp_bit;
    logic        exp_valid;
    logic        exp_strobe;
    logic [31:0] exp_count;

    function automatic int order_of(input logic [1:0] mode);
        case (mode)
            2'b01:   return 9;
            2'b10:   return 15;
            default: return 7;
        endcase
    endfunction

    function automatic int tap_of(input logic [1:0] mode);
        case (mode)
            2'b01:   return 5;
            2'b10:   return 14;
            default: return 6;
        endcase
    endfunction

    task automatic model_reset();
        m_n = 7;
        m_t = 6;
        hist.delete();
        repeat (7) hist.push_back(1'b1);
        since_load = 0;
        exp_bit = 1'b0; exp_valid = 1'b0; exp_strobe = 1'b0; exp_count = 32'd0;
    endtask

    task automatic model_load(input logic [14:0] seed, input logic [1:0] mode);
        int masked;
        m_n = order_of(mode);
        m_t = tap_of(mode);
        masked = int'(seed) & ((1 << m_n) - 1);
        if (masked == 0) masked = (1 << m_n) - 1;
        hist.delete();
        for (int j = m_n - 1; j >= 0; j--) hist.push_back(masked[j]);
        since_load = 0;
        exp_count = 32'd0; exp_valid = 1'b0; exp_strobe = 1'b0;
    endtask

    task automatic model_step();
        g_bit = hist[0] ^ hist[m_n - m_t];
        hist.push_back(g_bit);
        void'(hist.pop_front());
        since_load++;
        exp_count++;
        exp_bit    = g_bit ^ (INJ && (since_load % ERRP == 0));
        exp_valid  = 1'b1;
        exp_strobe = (since_load % ((1 << m_n) - 1) == 0);
    endtask

    task automatic tick(input logic en, input logic ld, input logic [14:0] seed, input logic [1:0] mode);
        bus.i_enable = en;
        bus.i_load   = ld;
        bus.i_seed   = seed;
        bus.i_mode   = mode;
        @(posedge clock);
        if (ld) model_load(seed, mode);
        else if (en) model_step();
        else begin exp_valid = 1'b0; exp_strobe = 1'b0; end
        #1;
    endtask

    task automatic test_reset();
        bus.i_enable = 1'b0; bus.i_load = 1'b0; bus.i_seed = 15'd0; bus.i_mode = 2'b00;
        i_reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        model_reset();
        n_checks++;
        if ({bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_values: got bit=%b valid=%b strobe=%b count=%0d, expected all 0",
                     bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count);
        end
        i_reset_n = 1'b1;
    endtask

    task automatic test_prbs7_continuous();
        logic [6:0] first7 = 7'd0;
        int strobes[$];
        for (int k = 1; k <= 254; k++) begin
            tick(1'b1, 1'b0, 15'($urandom), 2'($urandom));
            if (k <= 7) first7 = {first7[5:0], bus.o_bit};
            if (bus.o_period_strobe) strobes.push_back(k);
            n_checks++;
            if ({bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count} !== {exp_bit, exp_valid, exp_strobe, exp_count}) begin
                n_fail++;
                $display("FAIL prbs7_stream bit %0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", k,
                         bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count, exp_bit, exp_valid, exp_strobe, exp_count);
            end
        end
        n_checks++;
        if (first7 !== 7'b0000001) begin
            n_fail++;
            $display("FAIL prbs7_first7: got %b expected 0000001", first7);
        end
        n_checks++;
        if (strobes.size() != 2 || strobes[0] != 127 || strobes[1] != 254) begin
            n_fail++;
            $display("FAIL prbs7_strobe_pos: got %0d strobes (first at %0d) expected 2 at 127,254",
                     strobes.size(), (strobes.size() > 0) ? strobes[0] : -1);
        end
    endtask

    task automatic test_prbs9_zero_seed();
        int strobes[$];
        tick(1'b1, 1'b1, 15'd0, 2'b01);
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_bit_count !== 32'd0) begin
            n_fail++;
            $display("FAIL prbs9_load: got valid=%b count=%0d expected valid=0 count=0", bus.o_valid, bus.o_bit_count);
        end
        for (int k = 1; k <= 530; k++) begin
            tick(1'b1, 1'b0, 15'($urandom), 2'($urandom));
            if (bus.o_period_strobe) strobes.push_back(k);
            n_checks++;
            if ({bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count} !== {exp_bit, exp_valid, exp_strobe, exp_count}) begin
                n_fail++;
                $display("FAIL prbs9_stream bit %0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", k,
                         bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count, exp_bit, exp_valid, exp_strobe, exp_count);
            end
        end
        n_checks++;
        if (strobes.size() != 1 || strobes[0] != 511) begin
            n_fail++;
            $display("FAIL prbs9_strobe_pos: got %0d strobes expected 1 at bit 511", strobes.size());
        end
    endtask

    task automatic test_prbs15_period();
        bit first[200];
        int strobes[$];
        int errs = 0;
        bit raw;
        tick(1'($urandom), 1'b1, 15'($urandom), 2'b10);
        for (int k = 1; k <= 32767 + 200; k++) begin
            tick(1'b1, 1'b0, 15'($urandom), 2'($urandom));
            raw = bus.o_bit ^ (INJ && (k % ERRP == 0));
            if (k <= 200) first[k-1] = raw;
            else if (k > 32767 && raw != first[k-32768]) errs++;
            if (bus.o_period_strobe) strobes.push_back(k);
            n_checks++;
            if ({bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count} !== {exp_bit, exp_valid, exp_strobe, exp_count}) begin
                n_fail++;
                $display("FAIL prbs15_stream bit %0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", k,
                         bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count, exp_bit, exp_valid, exp_strobe, exp_count);
            end
        end
        n_checks++;
        if (strobes.size() != 1 || strobes[0] != 32767) begin
            n_fail++;
            $display("FAIL prbs15_strobe_pos: got %0d strobes expected 1 at bit 32767", strobes.size());
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL prbs15_repeat: got %0d differing bits expected 0", errs);
        end
    endtask

    task automatic test_enable_toggle();
        logic en;
        tick(1'b0, 1'b1, 15'($urandom), 2'b01);
        for (int k = 0; k < 400; k++) begin
            if (k >= 10 && k < 14) en = (k == 10 || k == 13);
            else en = 1'($urandom);
            tick(en, 1'b0, 15'($urandom), 2'($urandom));
            n_checks++;
            if ({bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count} !== {exp_bit, exp_valid, exp_strobe, exp_count}) begin
                n_fail++;
                $display("FAIL enable_toggle cycle %0d en=%b: got %b/%b/%b/%0d expected %b/%b/%b/%0d", k, en,
                         bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count, exp_bit, exp_valid, exp_strobe, exp_count);
            end
        end
    endtask

    task automatic test_load_priority();
        logic [1:0] mode;
        for (int r = 0; r < 6; r++) begin
            mode = 2'($urandom);
            for (int k = 0; k < 40; k++) begin
                tick((k == 0) ? 1'b1 : 1'($urandom), (k == 0), 15'($urandom), mode);
                n_checks++;
                if ({bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count} !== {exp_bit, exp_valid, exp_strobe, exp_count}) begin
                    n_fail++;
                    $display("FAIL load_priority round %0d cycle %0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", r, k,
                             bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count, exp_bit, exp_valid, exp_strobe, exp_count);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b1, 15'($urandom), 2'b01);
        repeat (20) tick(1'b1, 1'b0, 15'd0, 2'b01);
        #2;
        i_reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count} !== 35'd0) begin
            n_fail++;
            $display("FAIL async_reset: got bit=%b valid=%b strobe=%b count=%0d expected all 0",
                     bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count);
        end
        @(posedge clock);
        #1;
        i_reset_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick(1'b1, 1'b0, 15'($urandom), 2'b10);
            n_checks++;
            if ({bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count} !== {exp_bit, exp_valid, exp_strobe, exp_count}) begin
                n_fail++;
                $display("FAIL after_reset_prbs7 bit %0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", k,
                         bus.o_bit, bus.o_valid, bus.o_period_strobe, bus.o_bit_count, exp_bit, exp_valid, exp_strobe, exp_count);
            end
        end
    endtask

    task automatic test_error_inject();
        int diffs = 0;
        int misplaced = 0;
        tick(1'b0, 1'b1, 15'($urandom), 2'($urandom));
        for (int k = 1; k <= 1000; k++) begin
            tick(1'b1, 1'b0, 15'($urandom), 2'($urandom));
            if (bus.o_bit !== g_bit) begin
                diffs++;
                if (k % ERRP != 0) misplaced++;
            end
            n_checks++;
            if (bus.o_bit !== exp_bit) begin
                n_fail++;
                $display("FAIL inject_stream bit %0d: got %b expected %b", k, bus.o_bit, exp_bit);
            end
        end
        n_checks++;
        if (diffs != (INJ ? 1000 / ERRP : 0) || misplaced != 0) begin
            n_fail++;
            $display("FAIL inject_count: got %0d differing bits (%0d misplaced) expected %0d",
                     diffs, misplaced, INJ ? 1000 / ERRP : 0);
        end
    endtask

    initial begin
        test_reset();
        test_prbs7_continuous();
        test_prbs9_zero_seed();
        test_prbs15_period();
        test_enable_toggle();
        test_load_priority();
        test_async_reset();
        test_error_inject();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
